// File: rtl/output_serializer_pkg.sv
// Shared constants and FSM encoding for the matrix-multiply output path.
package output_serializer_pkg;

  localparam int DEF_OUTPUT_FEATURES     = 8;
  localparam int DEF_LOG_OUTPUT_FEATURES = 3;
  localparam int DEF_OUTPUT_WIDTH        = 16;
  localparam int DEF_LOG_BATCH_SIZE      = 3;
  localparam int DEF_RESULT_WIDTH        = 8;
  localparam int DEF_SHIFT               = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/output_serializer_row_fifo.sv
// Row buffer FIFO: power-of-two depth, simultaneous push/pop, occupancy count.
module row_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [DEPTH_LOG:0]   count_o
);

  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;

  // Extra pointer bit separates full from empty; count can never exceed DEPTH.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = count_o[DEPTH_LOG];
  assign empty_o = (count_o == '0);
  assign rdata_o = mem_q[rd_ptr_q[DEPTH_LOG-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/output_serializer.sv
// Buffers result rows and streams them out one quantized feature per transfer.
module output_serializer
  import output_serializer_pkg::*;
#(
  parameter int OUTPUT_FEATURES     = DEF_OUTPUT_FEATURES,
  parameter int LOG_OUTPUT_FEATURES = DEF_LOG_OUTPUT_FEATURES,
  parameter int OUTPUT_WIDTH        = DEF_OUTPUT_WIDTH,
  parameter int LOG_BATCH_SIZE      = DEF_LOG_BATCH_SIZE,
  parameter int RESULT_WIDTH        = DEF_RESULT_WIDTH,
  parameter int SHIFT               = DEF_SHIFT
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData,
  input  logic [LOG_BATCH_SIZE-1:0]               outputAddr,
  input  logic                                    outputWrEn,
  output logic [RESULT_WIDTH-1:0]                 resultData,
  output logic [LOG_BATCH_SIZE-1:0]               resultRow,
  output logic [LOG_OUTPUT_FEATURES-1:0]          resultFeature,
  output logic                                    resultValid,
  input  logic                                    resultReady,
  output logic                                    resultLast,
  output logic                                    overflow,
  output state_e                                  dbg_state
);

  localparam int DATA_W = OUTPUT_FEATURES * OUTPUT_WIDTH;
  localparam int ROW_W  = LOG_BATCH_SIZE + DATA_W;
  localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_IDX =
    LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);
  localparam logic signed [OUTPUT_WIDTH:0] RESULT_MAX =
    (OUTPUT_WIDTH+1)'((1 << RESULT_WIDTH) - 1);

  function automatic logic [RESULT_WIDTH-1:0] quantize(input logic [OUTPUT_WIDTH-1:0] raw);
    logic signed [OUTPUT_WIDTH:0] shifted;
    shifted = $signed({raw[OUTPUT_WIDTH-1], raw}) >>> SHIFT;
    if (shifted[OUTPUT_WIDTH])        return '0;
    else if (shifted > RESULT_MAX)    return '1;
    else                              return shifted[RESULT_WIDTH-1:0];
  endfunction

  state_e                           state_q;
  logic [LOG_OUTPUT_FEATURES-1:0]   feat_idx_q;
  logic                             valid_q;
  logic                             last_q;
  logic                             overflow_q;
  logic [RESULT_WIDTH-1:0]          data_q;
  logic [LOG_BATCH_SIZE-1:0]        row_q;
  logic [LOG_OUTPUT_FEATURES-1:0]   feature_q;

  logic [ROW_W-1:0]                 fifo_rdata;
  logic                             fifo_full, fifo_empty;
  logic [LOG_BATCH_SIZE:0]          fifo_count;
  logic [LOG_BATCH_SIZE-1:0]        head_addr;
  logic [DATA_W-1:0]                head_data;
  logic [OUTPUT_WIDTH-1:0]          head_feature;
  logic                             issue, row_done, push, drop;

  // The FIFO head is the row being sent; its slot is retired once the last
  // feature moves into the output register, so the next row follows with no gap.
  assign head_addr    = fifo_rdata[ROW_W-1 -: LOG_BATCH_SIZE];
  assign head_data    = fifo_rdata[DATA_W-1:0];
  assign head_feature = head_data[feat_idx_q*OUTPUT_WIDTH +: OUTPUT_WIDTH];

  // Handshake: a beat transfers on a rising edge where resultValid & resultReady;
  // while valid is high and ready low the output register holds every field.
  assign issue    = (state_q == ST_SEND) && (!valid_q || resultReady);
  assign row_done = issue && (feat_idx_q == LAST_IDX);
  assign push     = outputWrEn && (!fifo_full || row_done);
  assign drop     = outputWrEn && fifo_full && !row_done;

  row_fifo #(
    .WIDTH     (ROW_W),
    .DEPTH_LOG (LOG_BATCH_SIZE)
  ) u_row_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (row_done),
    .wdata_i ({outputAddr, outputData}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      feat_idx_q <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= '0;
      row_q      <= '0;
      feature_q  <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q    <= ST_SEND;
            feat_idx_q <= '0;
          end
        end
        ST_SEND: begin
          if (row_done) begin
            feat_idx_q <= '0;
            if (fifo_count <= (LOG_BATCH_SIZE+1)'(1)) state_q <= ST_IDLE;
          end else if (issue) begin
            feat_idx_q <= feat_idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (issue) begin
        valid_q   <= 1'b1;
        data_q    <= quantize(head_feature);
        row_q     <= head_addr;
        feature_q <= feat_idx_q;
        last_q    <= (feat_idx_q == LAST_IDX);
      end else if (valid_q && resultReady) begin
        valid_q   <= 1'b0;
        last_q    <= 1'b0;
      end
    end
  end

  assign resultValid   = valid_q;
  assign resultLast    = last_q;
  assign resultData    = data_q;
  assign resultRow     = row_q;
  assign resultFeature = feature_q;
  assign overflow      = overflow_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_output_serializer.sv
// Bench for output_serializer: row-level model with beat queue, per-cycle compare.
module tb_output_serializer;
  import output_serializer_pkg::*;

  localparam int NF = 8;
  localparam int OW = 16;
  localparam int LB = 3;
  localparam int LF = 3;
  localparam int RW = 8;
  localparam int BW = LB + LF + 1 + RW;
  localparam int DEPTH = 1 << LB;

  logic              clk;
  logic              reset;
  logic [NF*OW-1:0]  outputData;
  logic [LB-1:0]     outputAddr;
  logic              outputWrEn;
  logic [RW-1:0]     resultData;
  logic [LB-1:0]     resultRow;
  logic [LF-1:0]     resultFeature;
  logic              resultValid;
  logic              resultReady;
  logic              resultLast;
  logic              overflow;
  state_e            dbg_state;

  output_serializer #(
    .OUTPUT_FEATURES     (NF),
    .LOG_OUTPUT_FEATURES (LF),
    .OUTPUT_WIDTH        (OW),
    .LOG_BATCH_SIZE      (LB),
    .RESULT_WIDTH        (RW),
    .SHIFT               (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .outputData    (outputData),
    .outputAddr    (outputAddr),
    .outputWrEn    (outputWrEn),
    .resultData    (resultData),
    .resultRow     (resultRow),
    .resultFeature (resultFeature),
    .resultValid   (resultValid),
    .resultReady   (resultReady),
    .resultLast    (resultLast),
    .overflow      (overflow),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int rdy_mode = 0;
  initial begin
    resultReady = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       resultReady = 1'b0;
        1:       resultReady = 1'b1;
        default: resultReady = ~resultReady;
      endcase
    end
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [RW-1:0] log_q[$];
  int   rows_in_flight = 0;
  logic exp_overflow = 1'b0;
  logic prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  int   cur_run = 0;
  int   max_run = 0;
  int   last_cnt = 0;
  int   first_valid_cyc = -2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Quantization straight from the arithmetic rule: floor(x/16) clamped to 0..255.
  function automatic logic [RW-1:0] q8(input logic [OW-1:0] f);
    int v;
    v = int'($signed(f));
    v = v >>> 4;
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return RW'(v);
  endfunction

  function automatic logic [NF*OW-1:0] mk_row(input int base, input int step);
    logic [NF*OW-1:0] r;
    for (int k = 0; k < NF; k++) r[k*OW +: OW] = OW'(base + k*step);
    return r;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; the write is sampled on the next edge.
  task automatic drive_row(input logic [LB-1:0] addr, input logic [NF*OW-1:0] data);
    outputAddr = addr;
    outputData = data;
    outputWrEn = 1'b1;
    @(posedge clk);
    if (rows_in_flight < DEPTH) begin
      rows_in_flight++;
      for (int k = 0; k < NF; k++)
        exp_q.push_back({addr, LF'(k), (k == NF-1), q8(data[k*OW +: OW])});
    end else begin
      exp_overflow = 1'b1;
    end
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [BW-1:0] got;
    if (reset) begin
      chk("rst_valid", resultValid, 0);
      chk("rst_last", resultLast, 0);
      chk("rst_data", resultData, 0);
      chk("rst_row", resultRow, 0);
      chk("rst_feature", resultFeature, 0);
      prev_stall = 1'b0;
      cur_run = 0;
    end else begin
      chk("overflow", overflow, exp_overflow);
      if (resultValid) begin
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
        if (first_valid_cyc == -1) first_valid_cyc = cyc;
        got = {resultRow, resultFeature, resultLast, resultData};
        if (prev_stall) chk("stall_hold", got, prev_beat);
        if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
        else chk("beat", got, exp_q[0]);
        if (resultReady) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          log_q.push_back(resultData);
          if (resultLast) begin
            last_cnt++;
            rows_in_flight--;
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_beat  = got;
        end
      end else begin
        if (prev_stall) chk("valid_dropped_in_stall", 0, 1);
        prev_stall = 1'b0;
        cur_run = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    n_checks++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [NF*OW-1:0] r0;
    logic [RW-1:0]    exp35 [NF];
    int wr_edge;
    int found;

    reset      = 1'b1;
    outputWrEn = 1'b0;
    outputAddr = '0;
    outputData = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", resultValid, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_state", dbg_state, ST_IDLE);
    @(negedge clk);
    #1 reset = 1'b0;

    // Single row, ready high: quantization, last flag, two-cycle latency.
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    r0 = '0;
    r0[0*OW +: OW] = 16'h0123;
    r0[1*OW +: OW] = 16'hFFF0;
    r0[2*OW +: OW] = 16'h1000;
    r0[3*OW +: OW] = 16'h0FF0;
    exp35[0] = 8'h12; exp35[1] = 8'h00; exp35[2] = 8'hFF; exp35[3] = 8'hFF;
    exp35[4] = 8'h00; exp35[5] = 8'h00; exp35[6] = 8'h00; exp35[7] = 8'h00;
    log_q.delete();
    last_cnt = 0;
    first_valid_cyc = -1;
    drive_row(3'd0, r0);
    outputWrEn = 1'b0;
    wr_edge = cyc;
    wait_drain();
    chk("first_valid_latency", first_valid_cyc - wr_edge, 2);
    chk("row0_beats", log_q.size(), NF);
    for (int k = 0; k < NF; k++) chk($sformatf("row0_data%0d", k), log_q[k], exp35[k]);
    chk("row0_last_count", last_cnt, 1);

    // Two rows back-to-back: one unbroken 16-beat run.
    max_run = 0;
    drive_row(3'd3, mk_row(-768, 336));
    drive_row(3'd5, mk_row(3840, 288));
    outputWrEn = 1'b0;
    wait_drain();
    chk("b2b_run_length", max_run, 16);

    // Ready toggling every cycle: holds during stalls, each beat once.
    rdy_mode = 2;
    last_cnt = 0;
    drive_row(3'd6, mk_row(100, 700));
    drive_row(3'd1, mk_row(-2000, 900));
    outputWrEn = 1'b0;
    wait_drain();
    chk("toggle_rows", last_cnt, 2);
    rdy_mode = 1;

    // Nine writes into a stalled sink: eighth fills the buffer, ninth dropped.
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    last_cnt = 0;
    for (int r = 0; r < 9; r++) drive_row(LB'(r), mk_row(r*256 + 16, 16));
    outputWrEn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_stalled_valid", resultValid, 1);
    rdy_mode = 1;
    wait_drain();
    chk("ovf_rows_emitted", last_cnt, 8);
    chk("ovf_sticky", overflow, 1);

    // Reset during feature 3 with two rows queued behind it.
    @(posedge clk);
    #1;
    drive_row(3'd2, mk_row(1024, 64));
    drive_row(3'd4, mk_row(2048, 64));
    drive_row(3'd7, mk_row(512, 64));
    outputWrEn = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (resultValid && resultFeature == 3'd3) found = 1;
    end
    chk("reach_feature3", found, 1);
    #1;
    reset = 1'b1;
    exp_q.delete();
    rows_in_flight = 0;
    exp_overflow = 1'b0;
    #1;
    chk("midrst_valid", resultValid, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_state", dbg_state, ST_IDLE);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_quiet", resultValid, 0);
    last_cnt = 0;
    drive_row(3'd1, mk_row(2048, -256));
    outputWrEn = 1'b0;
    wait_drain();
    chk("post_rst_row", last_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 SHALL have parameter OUTPUT_FEATURES, default 8: features per result row.
REQ-002 SHALL have parameter LOG_OUTPUT_FEATURES, default 3: log2(OUTPUT_FEATURES).
REQ-003 SHALL have parameter OUTPUT_WIDTH, default 16: signed accumulator width per feature.
REQ-004 SHALL have parameter LOG_BATCH_SIZE, default 3: row address width; FIFO depth = 2^LOG_BATCH_SIZE.
REQ-005 SHALL have parameter RESULT_WIDTH, default 8: unsigned quantized result width.
REQ-006 SHALL have parameter SHIFT, default 4: arithmetic right-shift applied before clamping.
REQ-007 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-008 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-009 SHALL have port outputData  in  OUTPUT_FEATURES*OUTPUT_WIDTH  result row from matrix-multiply stage; feature k at bits [k*OUTPUT_WIDTH +: OUTPUT_WIDTH].
REQ-010 SHALL have port outputAddr  in  LOG_BATCH_SIZE  batch row index of outputData.
REQ-011 SHALL have port outputWrEn  in  1  qualifies outputData/outputAddr for one cycle.
REQ-012 SHALL have port resultData  out  RESULT_WIDTH  quantized feature value.
REQ-013 SHALL have port resultRow  out  LOG_BATCH_SIZE  row index of resultData.
REQ-014 SHALL have port resultFeature  out  LOG_OUTPUT_FEATURES  feature index of resultData.
REQ-015 SHALL have port resultValid  out  1  resultData/Row/Feature valid.
REQ-016 SHALL have port resultReady  in  1  downstream accepts when high with resultValid.
REQ-017 SHALL have port resultLast  out  1  high with feature OUTPUT_FEATURES-1 of a row.
REQ-018 SHALL have port overflow  out  1  sticky: a row write was dropped.

Function
REQ-019 SHALL buffer {outputAddr, outputData} in a FIFO of 2^LOG_BATCH_SIZE entries on each cycle outputWrEn=1.
REQ-020 SHALL accept a write when FIFO not full, or when full and a pop occurs the same cycle.
REQ-021 SHALL drop a write otherwise, leave FIFO unchanged, set overflow=1 until reset.
REQ-022 SHALL implement FSM IDLE/SEND; IDLE: FIFO non-empty -> pop head into row register, featureIdx=0, go SEND.
REQ-023 SHALL in SEND drive resultValid=1, resultFeature=featureIdx, resultRow=stored row address.
REQ-024 SHALL on transfer (resultValid & resultReady) with featureIdx<OUTPUT_FEATURES-1 increment featureIdx.
REQ-025 SHALL on transfer of last feature: FIFO non-empty -> pop next row, featureIdx=0, stay SEND (no bubble); else go IDLE.
REQ-026 SHALL hold resultData/Row/Feature/Last stable while resultValid=1 and resultReady=0.
REQ-027 SHALL compute resultData = clamp(feature >>> SHIFT, 0, 2^RESULT_WIDTH-1), shift signed arithmetic.
REQ-028 SHALL produce first resultValid two cycles after the edge sampling outputWrEn when FIFO empty and FSM IDLE.
REQ-029 SHALL emit rows in FIFO arrival order, regardless of outputAddr value.

Reset
REQ-030 SHALL on reset=1 asynchronously set FSM=IDLE, FIFO empty, featureIdx=0, overflow=0.
REQ-031 SHALL drive resultValid=0, resultLast=0, resultData=0, resultRow=0, resultFeature=0 during and after reset until a row loads.
REQ-032 SHALL discard any partially sent row and buffered rows on reset mid-operation.

Structure
REQ-033 SHALL place default parameter constants and the IDLE/SEND state encoding in the shared package used by the matrix-multiply blocks.
REQ-034 SHALL implement the buffer as sub-module row_fifo (parameterised width/depth, full/empty, simultaneous push/pop).

Verification
REQ-035 Row 0 features {0x0123,0xFFF0,0x1000,0x0FF0,0,0,0,0}, resultReady=1 -> resultData 0x12,0x00,0xFF,0xFF,0,0,0,0; resultLast with feature 7; valid 2 cycles after write.
REQ-036 Rows 3 then 5 back-to-back, resultReady=1 -> 16 consecutive valid cycles, resultRow 3 x8 then 5 x8, no bubble.
REQ-037 resultReady toggling 1/0 each cycle -> outputs constant during stalls; each feature transferred exactly once.
REQ-038 resultReady=0, 9 consecutive writes -> first 8 rows retained, overflow=1; after ready=1, 8 rows emitted, overflow stays 1.
REQ-039 Reset asserted at feature 3 of a row with 2 rows buffered -> resultValid=0 immediately; no further output until new write.
